ampel_sequencer: RTL and testbench
==================================

Name: ampel_sequencer

Overview:
- Upstream stage of the traffic-light colour decoder: generates the 3-bit phase counter that the decoder maps to a colour.
- Decoder mapping: 0 = red&yellow, 1–2 = green, 3–4 = yellow, 5–7 = red.
- Advances the counter once every TICK_DIV clocks.
- Can extend green by holding at counter 2 until a pedestrian request arrives or a hold limit expires.
- Acknowledges pedestrian requests when red begins.

Parameters:
- TICK_DIV, 4: clock cycles per step tick; legal range 1..65535; prescaler is 16 bits.
- MAX_GREEN_HOLD, 3: extra ticks the counter may stay at 2 awaiting a request; legal range 0..255; 0 disables hold.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  level; 0 freezes sequencing.
- ped_req  in  1  pedestrian request; sampled every clock, any high cycle registers a request.
- counter  out  3  phase counter to the colour decoder; registered.
- step  out  1  one-cycle pulse in the cycle counter has just changed.
- green_hold  out  1  high while the FSM is in HOLD.
- ped_ack  out  1  one-cycle pulse acknowledging a pending request.

Behaviour:
- Reset (async, active-high, immediate):
  - counter=3'd5 (safe red); step=0, green_hold=0, ped_ack=0.
  - state=RUN; prescaler=0, hold_cnt=0, pending=0.
- Prescaler: while enable=1, counts 0..TICK_DIV-1 and wraps. tick = enable & (prescaler==TICK_DIV-1).
  - With enable high from reset release, the first tick occurs at the TICK_DIV-th rising edge.
- enable=0:
  - prescaler cleared to 0.
  - state, counter and hold_cnt frozen; no step.
  - pending still latches ped_req.
  - After re-enable, the next tick comes a full TICK_DIV cycles later.
- State RUN, on tick:
  - If counter==2, pending==0 and MAX_GREEN_HOLD>0: go to HOLD, hold_cnt<=0, counter unchanged, step=0.
  - Otherwise counter<=counter+1, wrapping 7->0 (3-bit modular), and step=1 in the following cycle.
- State HOLD, on tick:
  - If pending==1 or hold_cnt==MAX_GREEN_HOLD-1: counter<=3, state<=RUN, step pulses.
  - Else hold_cnt<=hold_cnt+1.
  - Without a request, counter therefore stays at 2 for 1+MAX_GREEN_HOLD tick periods.
- Request latch:
  - pending<=1 on any clock with ped_req=1.
  - Cleared on the clock that raises ped_ack.
  - If ped_req=1 in that same clock, pending stays 1 (new request wins).
- ped_ack:
  - Registered one-cycle pulse, asserted the clock after counter becomes 5 if pending==1 at that time.
  - No ack if pending==0. Never asserted for counter values other than 5.
- step, ped_ack: never high for two consecutive cycles. green_hold equals (state==HOLD).
- Counter only ever changes by +1 mod 8, except the HOLD exit 2->3, which is also +1; no other jumps.
- Reset mid-HOLD or mid-prescale returns immediately to reset values; any pending request is lost.

Test Plan:
- Reset/first ticks (TICK_DIV=4, MAX_GREEN_HOLD=3, enable=1, no ped_req).
  -> counter=5 during reset.
  -> After release, counter 6,7,0,1,2 at edges 4,8,12,16,20, with step pulsing after each.
- Green hold without request (continuing the same run).
  -> green_hold rises after edge 24; counter stays 2 through edge 32.
  -> counter=3 after edge 36, green_hold falls; then 4 at 40, 5 at 44.
  -> No ped_ack.
- Request during hold: one-cycle ped_req at edge 26.
  -> counter=3 after edge 28 (hold exits at next tick); 4 at 32; 5 at 36.
  -> ped_ack single pulse the cycle after counter=5; pending cleared.
- Request before green: ped_req pulse while counter=0.
  -> At counter 2 no HOLD is entered; green_hold never rises; 2->3 on the next tick.
  -> ped_ack follows counter=5.
- Enable gating: drop enable for 10 cycles mid-prescale at counter=7.
  -> counter stays 7, no step; after re-enable, counter=0 exactly 4 cycles later.
- Simultaneous request and ack, plus async reset.
  -> ped_req high on the ack cycle leaves pending=1, so the next cycle skips HOLD.
  -> Asserting rst mid-HOLD forces counter=5 and green_hold=0 without waiting for a clk edge.

Source files
------------

// File: rtl/ampel_sequencer_if.sv
// Handshake bundle between the traffic-light sequencer and its environment.
// The master drives enable/ped_req; the sequencer (slave) drives the phase outputs.
interface ampel_sequencer_if;
    logic       enable;
    logic       ped_req;
    logic [2:0] counter;
    logic       step;
    logic       green_hold;
    logic       ped_ack;

    modport master (
        output enable,
        output ped_req,
        input  counter,
        input  step,
        input  green_hold,
        input  ped_ack
    );

    modport slave (
        input  enable,
        input  ped_req,
        output counter,
        output step,
        output green_hold,
        output ped_ack
    );
endinterface

// File: rtl/ampel_sequencer.sv
// Phase counter generator feeding the traffic-light colour decoder.
// Optional green extension holds at phase 2 until a request or a hold limit.
module ampel_sequencer #(
    parameter int unsigned TICK_DIV       = 4,
    parameter int unsigned MAX_GREEN_HOLD = 3
) (
    input logic               clk,
    input logic               rst,
    ampel_sequencer_if.slave  bus
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(MAX_GREEN_HOLD - 1);
    localparam bit          HOLD_EN   = (MAX_GREEN_HOLD != 0);

    typedef enum logic {RUN, HOLD} state_e;

    state_e      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [2:0]  counter_q, counter_d;
    logic        pending_q, pending_d;
    logic        step_q, step_d;
    logic        green_hold_q, green_hold_d;
    logic        ped_ack_q, ped_ack_d;
    logic        tick;

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        hold_cnt_d = hold_cnt_q;
        step_d     = 1'b0;
        tick       = bus.enable && (presc_q == TICK_LAST);

        if (!bus.enable || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 16'd1;
        end

        if (tick) begin
            unique case (state_q)
                RUN: begin
                    if (counter_q == 3'd2 && !pending_q && HOLD_EN) begin
                        state_d    = HOLD;
                        hold_cnt_d = '0;
                    end else begin
                        counter_d = counter_q + 3'd1;
                        step_d    = 1'b1;
                    end
                end
                HOLD: begin
                    if (pending_q || hold_cnt_q == HOLD_LAST) begin
                        state_d   = RUN;
                        counter_d = 3'd3;
                        step_d    = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        // step_q marks the first cycle of a new phase, so this fires once per red entry
        ped_ack_d    = step_q && (counter_q == 3'd5) && pending_q;
        pending_d    = bus.ped_req || (pending_q && !ped_ack_d);
        green_hold_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            presc_q      <= '0;
            hold_cnt_q   <= '0;
            counter_q    <= 3'd5;
            pending_q    <= 1'b0;
            step_q       <= 1'b0;
            green_hold_q <= 1'b0;
            ped_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            hold_cnt_q   <= hold_cnt_d;
            counter_q    <= counter_d;
            pending_q    <= pending_d;
            step_q       <= step_d;
            green_hold_q <= green_hold_d;
            ped_ack_q    <= ped_ack_d;
        end
    end

    assign bus.counter    = counter_q;
    assign bus.step       = step_q;
    assign bus.green_hold = green_hold_q;
    assign bus.ped_ack    = ped_ack_q;

endmodule

// File: tb/tb_ampel_sequencer.sv
// Directed bench for ampel_sequencer with TICK_DIV=4, MAX_GREEN_HOLD=3.
// Edge numbers count rising edges after reset release.
module tb_ampel_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   ecount;

    ampel_sequencer_if bus ();

    ampel_sequencer #(
        .TICK_DIV       (4),
        .MAX_GREEN_HOLD (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic adv(input int target);
        while (ecount < target) begin
            @(posedge clk);
            #1;
            ecount++;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.enable     = 1'b1;
        bus.ped_req    = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        ecount = 0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        rst         = 1'b1;
        bus.enable  = 1'b1;
        bus.ped_req = 1'b0;
        #1;
        checks++;
        if (bus.counter !== 3'd5) begin
            failures++;
            $display("FAIL reset_counter got=%0d want=5", bus.counter);
        end
        checks++;
        if ({bus.step, bus.green_hold, bus.ped_ack} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000",
                     {bus.step, bus.green_hold, bus.ped_ack});
        end
        @(negedge clk);
        rst    = 1'b0;
        ecount = 0;
    endtask

    task automatic test_first_ticks();
        logic [2:0] exp;
        for (int k = 1; k <= 5; k++) begin
            exp = 3'(5 + k);
            adv(4 * k - 1);
            checks++;
            if (bus.counter !== 3'(exp - 3'd1)) begin
                failures++;
                $display("FAIL pre_tick_%0d got=%0d want=%0d",
                         k, bus.counter, 3'(exp - 3'd1));
            end
            adv(4 * k);
            checks++;
            if (bus.counter !== exp || bus.step !== 1'b1) begin
                failures++;
                $display("FAIL tick_%0d got=%0d/%b want=%0d/1",
                         k, bus.counter, bus.step, exp);
            end
            adv(4 * k + 1);
            checks++;
            if (bus.step !== 1'b0) begin
                failures++;
                $display("FAIL step_drop_%0d got=%b want=0", k, bus.step);
            end
        end
    endtask

    task automatic test_green_hold();
        adv(24);
        checks++;
        if (bus.green_hold !== 1'b1 || bus.counter !== 3'd2 || bus.step !== 1'b0) begin
            failures++;
            $display("FAIL hold_enter got=%b/%0d/%b want=1/2/0",
                     bus.green_hold, bus.counter, bus.step);
        end
        for (int e = 25; e <= 35; e++) begin
            adv(e);
            checks++;
            if (bus.counter !== 3'd2 || bus.green_hold !== 1'b1) begin
                failures++;
                $display("FAIL hold_stay_e%0d got=%0d/%b want=2/1",
                         e, bus.counter, bus.green_hold);
            end
        end
        adv(36);
        checks++;
        if (bus.counter !== 3'd3 || bus.green_hold !== 1'b0 || bus.step !== 1'b1) begin
            failures++;
            $display("FAIL hold_exit got=%0d/%b/%b want=3/0/1",
                     bus.counter, bus.green_hold, bus.step);
        end
        adv(40);
        checks++;
        if (bus.counter !== 3'd4) begin
            failures++;
            $display("FAIL after_hold_4 got=%0d want=4", bus.counter);
        end
        adv(44);
        checks++;
        if (bus.counter !== 3'd5) begin
            failures++;
            $display("FAIL after_hold_5 got=%0d want=5", bus.counter);
        end
        for (int e = 45; e <= 47; e++) begin
            adv(e);
            checks++;
            if (bus.ped_ack !== 1'b0) begin
                failures++;
                $display("FAIL no_ack_e%0d got=%b want=0", e, bus.ped_ack);
            end
        end
    endtask

    task automatic test_req_during_hold();
        do_reset();
        adv(25);
        bus.ped_req = 1'b1;
        adv(26);
        bus.ped_req = 1'b0;
        adv(27);
        checks++;
        if (bus.counter !== 3'd2 || bus.green_hold !== 1'b1) begin
            failures++;
            $display("FAIL req_hold_wait got=%0d/%b want=2/1",
                     bus.counter, bus.green_hold);
        end
        adv(28);
        checks++;
        if (bus.counter !== 3'd3 || bus.green_hold !== 1'b0) begin
            failures++;
            $display("FAIL req_hold_exit got=%0d/%b want=3/0",
                     bus.counter, bus.green_hold);
        end
        adv(32);
        checks++;
        if (bus.counter !== 3'd4) begin
            failures++;
            $display("FAIL req_hold_4 got=%0d want=4", bus.counter);
        end
        adv(36);
        checks++;
        if (bus.counter !== 3'd5 || bus.ped_ack !== 1'b0) begin
            failures++;
            $display("FAIL req_hold_5 got=%0d/%b want=5/0",
                     bus.counter, bus.ped_ack);
        end
        adv(37);
        checks++;
        if (bus.ped_ack !== 1'b1) begin
            failures++;
            $display("FAIL req_hold_ack got=%b want=1", bus.ped_ack);
        end
        adv(38);
        checks++;
        if (bus.ped_ack !== 1'b0) begin
            failures++;
            $display("FAIL req_hold_ack_pulse got=%b want=0", bus.ped_ack);
        end
        // pending must be gone, so the next green enters HOLD again
        adv(60);
        checks++;
        if (bus.counter !== 3'd2 || bus.green_hold !== 1'b1) begin
            failures++;
            $display("FAIL pending_cleared got=%0d/%b want=2/1",
                     bus.counter, bus.green_hold);
        end
    endtask

    task automatic test_req_before_green();
        do_reset();
        adv(12);
        bus.ped_req = 1'b1;
        adv(13);
        bus.ped_req = 1'b0;
        for (int e = 14; e <= 32; e++) begin
            adv(e);
            checks++;
            if (bus.green_hold !== 1'b0) begin
                failures++;
                $display("FAIL pre_green_hold_e%0d got=%b want=0",
                         e, bus.green_hold);
            end
        end
        adv(33);
        checks++;
        if (bus.counter !== 3'd5 || bus.ped_ack !== 1'b1) begin
            failures++;
            $display("FAIL pre_green_ack got=%0d/%b want=5/1",
                     bus.counter, bus.ped_ack);
        end
    endtask

    task automatic test_req_before_green_phase();
        do_reset();
        adv(12);
        bus.ped_req = 1'b1;
        adv(13);
        bus.ped_req = 1'b0;
        adv(20);
        checks++;
        if (bus.counter !== 3'd2) begin
            failures++;
            $display("FAIL pre_green_c2 got=%0d want=2", bus.counter);
        end
        adv(24);
        checks++;
        if (bus.counter !== 3'd3 || bus.step !== 1'b1) begin
            failures++;
            $display("FAIL pre_green_c3 got=%0d/%b want=3/1",
                     bus.counter, bus.step);
        end
        adv(34);
        checks++;
        if (bus.ped_ack !== 1'b0) begin
            failures++;
            $display("FAIL pre_green_ack_pulse got=%b want=0", bus.ped_ack);
        end
    endtask

    task automatic test_enable_gating();
        do_reset();
        adv(8);
        checks++;
        if (bus.counter !== 3'd7) begin
            failures++;
            $display("FAIL gate_c7 got=%0d want=7", bus.counter);
        end
        adv(9);
        bus.enable = 1'b0;
        for (int e = 10; e <= 19; e++) begin
            adv(e);
            checks++;
            if (bus.counter !== 3'd7 || bus.step !== 1'b0) begin
                failures++;
                $display("FAIL gate_frozen_e%0d got=%0d/%b want=7/0",
                         e, bus.counter, bus.step);
            end
        end
        bus.enable = 1'b1;
        adv(22);
        checks++;
        if (bus.counter !== 3'd7) begin
            failures++;
            $display("FAIL gate_early got=%0d want=7", bus.counter);
        end
        adv(23);
        checks++;
        if (bus.counter !== 3'd0 || bus.step !== 1'b1) begin
            failures++;
            $display("FAIL gate_resume got=%0d/%b want=0/1",
                     bus.counter, bus.step);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        adv(1);
        bus.ped_req = 1'b1;
        adv(2);
        bus.ped_req = 1'b0;
        adv(5);
        checks++;
        if (bus.ped_ack !== 1'b0) begin
            failures++;
            $display("FAIL no_ack_at_reset_red got=%b want=0", bus.ped_ack);
        end
        adv(24);
        checks++;
        if (bus.counter !== 3'd3 || bus.green_hold !== 1'b0) begin
            failures++;
            $display("FAIL skip_hold_1 got=%0d/%b want=3/0",
                     bus.counter, bus.green_hold);
        end
        adv(32);
        bus.ped_req = 1'b1;
        adv(33);
        bus.ped_req = 1'b0;
        checks++;
        if (bus.ped_ack !== 1'b1) begin
            failures++;
            $display("FAIL simul_ack got=%b want=1", bus.ped_ack);
        end
        adv(34);
        checks++;
        if (bus.ped_ack !== 1'b0) begin
            failures++;
            $display("FAIL simul_ack_pulse got=%b want=0", bus.ped_ack);
        end
        adv(56);
        checks++;
        if (bus.counter !== 3'd3 || bus.green_hold !== 1'b0) begin
            failures++;
            $display("FAIL skip_hold_2 got=%0d/%b want=3/0",
                     bus.counter, bus.green_hold);
        end
        adv(65);
        checks++;
        if (bus.counter !== 3'd5 || bus.ped_ack !== 1'b1) begin
            failures++;
            $display("FAIL second_ack got=%0d/%b want=5/1",
                     bus.counter, bus.ped_ack);
        end
        adv(89);
        checks++;
        if (bus.counter !== 3'd2 || bus.green_hold !== 1'b1) begin
            failures++;
            $display("FAIL mid_hold got=%0d/%b want=2/1",
                     bus.counter, bus.green_hold);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.counter !== 3'd5 || bus.green_hold !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got=%0d/%b want=5/0",
                     bus.counter, bus.green_hold);
        end
        @(negedge clk);
        rst    = 1'b0;
        ecount = 0;
        adv(4);
        checks++;
        if (bus.counter !== 3'd6 || bus.ped_ack !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_tick got=%0d/%b want=6/0",
                     bus.counter, bus.ped_ack);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        ecount      = 0;
        rst         = 1'b1;
        bus.enable  = 1'b0;
        bus.ped_req = 1'b0;
        test_reset();
        test_first_ticks();
        test_green_hold();
        test_req_during_hold();
        test_req_before_green();
        test_req_before_green_phase();
        test_enable_gating();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
